// File: rtl/reg_hazard_unit_pkg.sv
// Shared types and constants for the register hazard unit: register index width,
// the zero-register index, operand-forward encodings and the pipeline slot record.
package reg_hazard_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_read;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic             rm_used;
    } slot_t;

endpackage

// File: rtl/reg_hazard_unit_if.sv
// Decode-stage bundle between the pipeline control (master) and the hazard unit (slave).
interface reg_hazard_unit_if
    import reg_hazard_unit_pkg::*;
;
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_rm_used;
    logic [REG_W-1:0] id_dest;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [15:0]      stall_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_rm_used, id_dest, id_reg_write, id_mem_read, flush,
        input  stall, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rm_used, id_dest, id_reg_write, id_mem_read, flush,
        output stall, fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/reg_hazard_unit_hazard_cmp.sv
// Writer/source comparator: a slot matches a source only if it really writes a
// non-zero register and the source operand is actually read.
module hazard_cmp
    import reg_hazard_unit_pkg::*;
(
    input  slot_t            i_slot,
    input  logic [REG_W-1:0] i_src,
    input  logic             i_src_en,
    output logic             o_match
);

    logic w_writer;

    assign w_writer = i_slot.valid & i_slot.reg_write & (i_slot.dest != XZR);
    assign o_match  = w_writer & i_src_en & (i_slot.dest == i_src);

endmodule

// File: rtl/reg_hazard_unit.sv
// Register hazard unit: tracks EX/MEM/WB slots, raises stall and selects EX operand
// forwarding. Forwarding is built only when HAZARD_FORWARDING_EN is defined.
module reg_hazard_unit
    import reg_hazard_unit_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    reg_hazard_unit_if.slave bus
);

    slot_t       r_ex;
    slot_t       r_mem;
    slot_t       r_wb;
    logic [15:0] r_stall_cnt;

    slot_t w_id_slot;
    logic  w_hazard;
    logic  w_stall;

    assign w_id_slot = '{valid:     bus.id_valid,
                         dest:      bus.id_dest,
                         reg_write: bus.id_reg_write,
                         mem_read:  bus.id_mem_read,
                         rn:        bus.id_rn,
                         rm:        bus.id_rm,
                         rm_used:   bus.id_rm_used};

`ifdef HAZARD_FORWARDING_EN
    // 0/1: decode vs EX (load-use), 2/3: EX.rn vs MEM/WB, 4/5: EX.rm vs MEM/WB
    localparam int N_CMP = 6;
`else
    // 0/1: decode vs EX, 2/3: decode vs MEM
    localparam int N_CMP = 4;
`endif

    slot_t            w_cmp_slot [N_CMP];
    logic [REG_W-1:0] w_cmp_src  [N_CMP];
    logic             w_cmp_en   [N_CMP];
    logic             w_match    [N_CMP];

    genvar gi;
    generate
        for (gi = 0; gi < N_CMP; gi++) begin : g_cmp
            hazard_cmp u_cmp (
                .i_slot   (w_cmp_slot[gi]),
                .i_src    (w_cmp_src[gi]),
                .i_src_en (w_cmp_en[gi]),
                .o_match  (w_match[gi])
            );
        end
    endgenerate

    assign w_cmp_slot[0] = r_ex;
    assign w_cmp_src[0]  = bus.id_rn;
    assign w_cmp_en[0]   = 1'b1;
    assign w_cmp_slot[1] = r_ex;
    assign w_cmp_src[1]  = bus.id_rm;
    assign w_cmp_en[1]   = bus.id_rm_used;

`ifdef HAZARD_FORWARDING_EN
    assign w_cmp_slot[2] = r_mem;
    assign w_cmp_src[2]  = r_ex.rn;
    assign w_cmp_en[2]   = 1'b1;
    assign w_cmp_slot[3] = r_wb;
    assign w_cmp_src[3]  = r_ex.rn;
    assign w_cmp_en[3]   = 1'b1;
    assign w_cmp_slot[4] = r_mem;
    assign w_cmp_src[4]  = r_ex.rm;
    assign w_cmp_en[4]   = r_ex.rm_used & r_ex.valid;
    assign w_cmp_slot[5] = r_wb;
    assign w_cmp_src[5]  = r_ex.rm;
    assign w_cmp_en[5]   = r_ex.rm_used & r_ex.valid;

    // Only a load in EX cannot be covered by forwarding
    assign w_hazard  = (w_match[0] | w_match[1]) & r_ex.mem_read;
    assign bus.fwd_a = w_match[2] ? FWD_EXMEM : (w_match[3] ? FWD_MEMWB : FWD_REG);
    assign bus.fwd_b = w_match[4] ? FWD_EXMEM : (w_match[5] ? FWD_MEMWB : FWD_REG);
`else
    assign w_cmp_slot[2] = r_mem;
    assign w_cmp_src[2]  = bus.id_rn;
    assign w_cmp_en[2]   = 1'b1;
    assign w_cmp_slot[3] = r_mem;
    assign w_cmp_src[3]  = bus.id_rm;
    assign w_cmp_en[3]   = bus.id_rm_used;

    // WB needs no check: the register file writes before decode reads it
    assign w_hazard  = w_match[0] | w_match[1] | w_match[2] | w_match[3];
    assign bus.fwd_a = FWD_REG;
    assign bus.fwd_b = FWD_REG;
`endif

    assign w_stall       = bus.id_valid & ~bus.flush & w_hazard;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= (w_stall | bus.flush) ? '0 : w_id_slot;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Slot fields that only feed the shift chain in some builds
    logic w_unused;
    assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

// File: doc/reg_hazard_unit.md
REG_HAZARD_UNIT -- requirements
Module: reg_hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port id_valid, input, 1, decode-stage instruction present.
REQ-004 SHALL have ports id_rn, id_rm, input, 5 each, decode-stage source register numbers.
REQ-005 SHALL have port id_rm_used, input, 1, id_rm is a real source (0 for immediate forms).
REQ-006 SHALL have port id_dest, input, 5, destination register number from the Rt/Rd select mux.
REQ-007 SHALL have ports id_reg_write, id_mem_read, input, 1 each, decode-stage control bits.
REQ-008 SHALL have port flush, input, 1, squash the decode-stage instruction (taken branch).
REQ-009 SHALL have port stall, output, 1, hold PC and IF/ID and insert a bubble.
REQ-010 SHALL have ports fwd_a, fwd_b, output, 2 each, EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-011 SHALL have port stall_cnt, output, 16, saturating count of stall cycles.

Function
REQ-012 SHALL hold three in-flight slots EX, MEM, WB, each {valid, dest[4:0], reg_write, mem_read, rn, rm, rm_used}.
REQ-013 SHALL, each edge, shift WB<=MEM and MEM<=EX; EX<=decode fields when stall=0 and flush=0, else EX<=bubble (valid=0).
REQ-014 SHALL treat a slot as a writer only if valid=1, reg_write=1, and dest!=31 (XZR never hazards nor forwards).
REQ-015 SHALL assert stall combinationally when id_valid=1, flush=0, and EX is a writer with mem_read=1 whose dest equals id_rn, or equals id_rm with id_rm_used=1 (load-use).
REQ-016 SHALL drive fwd_a=10 when MEM is a writer and MEM.dest==EX.rn; else 01 when WB is a writer and WB.dest==EX.rn; else 00; MEM priority on double match.
REQ-017 SHALL drive fwd_b identically against EX.rm, and 00 when EX.rm_used=0 or EX.valid=0.
REQ-018 SHALL make stall_cnt increment by 1 each cycle stall=1, holding at 16'hFFFF.
REQ-019 SHALL give flush priority over stall: flush=1 forces stall=0 that cycle.
REQ-020 SHALL not count WB against decode; the register file writes in the first half-cycle and satisfies that case.

Reset
REQ-021 SHALL, while rst_n=0, clear all slot valid bits, stall_cnt=0; outputs stall=0, fwd_a=fwd_b=00.
REQ-022 SHALL discard in-flight slots on reset assertion mid-operation; first post-reset instruction sees no hazards.

Configuration
REQ-023 SHALL compile forwarding logic only when macro HAZARD_FORWARDING_EN is defined.
REQ-024 SHALL, without HAZARD_FORWARDING_EN, tie fwd_a=fwd_b=00 and assert stall on any decode source match against an EX or MEM writer, regardless of mem_read.

Structure
REQ-025 SHALL take from a shared package: register width 5, XZR index 31, fwd encodings FWD_REG/FWD_EXMEM/FWD_MEMWB, slot struct type.
REQ-026 SHALL instantiate one sub-module hazard_cmp (5-bit writer/source compare with XZR and valid qualification), used for every match.

Verification
REQ-027 SHALL cover: ADD X3 in EX, then SUB reading X3 via rn -> next cycle fwd_a=10; cycle after, with an independent instr between, fwd_a=01.
REQ-028 SHALL cover: LDUR X5 in EX, decode ADD rm=X5 rm_used=1 -> stall=1 one cycle, EX bubble, then fwd_b=01, stall_cnt=1.
REQ-029 SHALL cover: writer dest=31 followed by reader rn=31 -> stall=0, fwd_a=00.
REQ-030 SHALL cover: MEM and WB both dest=X7, EX reads X7 -> fwd_a=10 (MEM wins).
REQ-031 SHALL cover: load-use condition with flush=1 same cycle -> stall=0, EX bubble; and rst_n pulled low mid-stream -> all slots invalid, stall_cnt=0.
REQ-032 SHALL cover, HAZARD_FORWARDING_EN undefined: ADD X2 then ADD reading X2 -> stall=1 two cycles, fwd outputs 00 throughout.
